net_rtd_avg: RTL and testbench
==============================

Name: net_rtd_avg

Overview:
Round-trip-delay averaging stage placed directly upstream of the network pipelined divider.
- Collects a programmed number of (tx, rx) timestamp pairs and accumulates their modular differences.
- Issues a single divide request (sum / count) to the divider over its start/ready/end handshake.
- Captures the quotient and remainder and presents them as the averaged link delay.

Parameters:
DW, 32, timestamp, accumulator and divider operand width
CW, 8, width of sample-count config; max count 2^CW-1

Ports:
clk_i  in  1  single clock
rst_ni  in  1  reset, asynchronous, active-low
meas_start_i  in  1  pulse; latches cfg_num_i and begins a measurement
cfg_num_i  in  CW  number of samples to average
sample_vld_i  in  1  qualifies t_tx_i / t_rx_i this cycle
t_tx_i  in  DW  transmit timestamp
t_rx_i  in  DW  receive timestamp
div_start_o  out  1  one-cycle divide request
div_a_o  out  DW  dividend (accumulated sum)
div_b_o  out  DW  divisor (sample count, zero-extended)
div_ready_i  in  1  divider idle
div_end_i  in  1  divider result valid this cycle
div_q_i  in  DW  divider quotient
div_r_i  in  DW  divider remainder
avg_o  out  DW  averaged delay (registered)
avg_rem_o  out  DW  remainder of average (registered)
avg_vld_o  out  1  one-cycle pulse when avg_o updates
busy_o  out  1  high in every state except IDLE
err_o  out  1  sticky error flag; cleared by next accepted meas_start_i

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous and active-low.
- Reset values: FSM=IDLE; all outputs, accumulator and counters = 0.
- FSM states: IDLE, ACC, REQ, WAIT, DONE.
- IDLE:
  - meas_start_i=1 latches num=cfg_num_i, clears acc, cnt and err_o.
  - If num=0: set err_o, stay IDLE, no divider request.
  - Else: go to ACC.
  - sample_vld_i is ignored in IDLE.
- ACC:
  - Each sample_vld_i cycle: delta = (t_rx_i - t_tx_i) mod 2^DW, so timestamp wrap is handled. acc += delta; cnt += 1.
  - If the DW-bit add carries out: set err_o and saturate acc at all-ones; further adds keep acc saturated.
  - When cnt reaches num (the cycle of the last sample is counted): go to REQ next cycle.
- meas_start_i outside IDLE is ignored. No restart mid-measurement.
- REQ:
  - Drive div_a_o=acc and div_b_o=num; hold both stable from REQ until WAIT exits.
  - Assert div_start_o for exactly one cycle, in the first REQ cycle where div_ready_i=1; go to WAIT.
  - If div_ready_i=0, stay in REQ with div_start_o=0.
- WAIT: on div_end_i=1, register avg_o=div_q_i and avg_rem_o=div_r_i; go to DONE. A div_end_i seen in any other state is ignored.
- DONE: avg_vld_o=1 for one cycle; go to IDLE.
- Latency: last sample cycle → div_start_o is 1 cycle, provided div_ready_i is already high. div_end_i → avg_vld_o is 1 cycle.
- avg_o / avg_rem_o hold their value until the next completed measurement.
- err_o does not abort a measurement; the saturated sum is still divided.
- Reset mid-operation: immediate return to reset values. No divider request is pending afterwards.

Optional Feature:
Macro: RTD_MINMAX_EN
- Defined:
  - Adds outputs dmin_o and dmax_o (DW bits each), reset to 0.
  - On the first sample of a measurement: dmin=dmax=delta.
  - On later samples: unsigned min/max update.
  - dmin_o/dmax_o are registered and updated together with avg_vld_o.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Basic average: num=4, pairs (tx,rx)=(0,10),(100,112),(200,214),(300,316) → div_a_o=52, div_b_o=4. Divider model returns q=13, r=0 → avg_o=13, avg_rem_o=0, one avg_vld_o pulse, err_o=0.
- Wrap-around: DW=32, num=1, tx=0xFFFFFFF0, rx=0x00000010 → div_a_o=0x20. Returns q=0x20 → avg_o=0x20.
- Zero count and overflow:
  - num=0 → err_o=1, busy_o never asserts, div_start_o never asserts.
  - num=2 with deltas 0xFFFFFFFF and 0x2 → err_o=1, div_a_o=0xFFFFFFFF.
- Divider backpressure: div_ready_i held 0 for 5 cycles after the last sample → div_start_o stays 0. It pulses once on the first div_ready_i=1 cycle, with div_a_o/div_b_o stable throughout.
- Ignored events:
  - meas_start_i during ACC with new cfg_num_i=9 → original num is kept.
  - sample_vld_i in IDLE → acc is unchanged.
  - div_end_i in IDLE → avg_o is unchanged.
- Reset mid-operation: rst_ni asserted in WAIT → all outputs 0 asynchronously. After release, a fresh num=1, delta=7 measurement gives avg_o=7 (RTD_MINMAX_EN: dmin_o=dmax_o=7).

Source files
------------

// File: rtl/net_rtd_avg.sv
// Round-trip-delay averager: accumulates (rx - tx) deltas, then divides sum by count via an external divider.
// Optional RTD_MINMAX_EN adds registered per-measurement min/max delta outputs.
module net_rtd_avg #(
    parameter int DW = 32,
    parameter int CW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          meas_start_i,
    input  logic [CW-1:0] cfg_num_i,
    input  logic          sample_vld_i,
    input  logic [DW-1:0] t_tx_i,
    input  logic [DW-1:0] t_rx_i,
    output logic          div_start_o,
    output logic [DW-1:0] div_a_o,
    output logic [DW-1:0] div_b_o,
    input  logic          div_ready_i,
    input  logic          div_end_i,
    input  logic [DW-1:0] div_q_i,
    input  logic [DW-1:0] div_r_i,
    output logic [DW-1:0] avg_o,
    output logic [DW-1:0] avg_rem_o,
    output logic          avg_vld_o,
    output logic          busy_o,
`ifdef RTD_MINMAX_EN
    output logic [DW-1:0] dmin_o,
    output logic [DW-1:0] dmax_o,
`endif
    output logic          err_o
);

    typedef enum logic [2:0] {IDLE, ACC, REQ, WAIT, DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] num_q, num_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] avg_q, avg_d;
    logic [DW-1:0] rem_q, rem_d;
    logic          err_q, err_d;
    logic [DW-1:0] delta;
    logic [DW:0]   sum_w;
`ifdef RTD_MINMAX_EN
    logic [DW-1:0] mn_q, mn_d, mx_q, mx_d;
    logic [DW-1:0] dmin_q, dmin_d, dmax_q, dmax_d;
`endif

    // Returns {carry, sum}; on carry the sum is pinned at all-ones.
    function automatic logic [DW:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[DW]) begin
            s = {1'b1, {DW{1'b1}}};
        end
        return s;
    endfunction

    // Modular subtraction absorbs a timestamp wrap between tx and rx.
    assign delta = t_rx_i - t_tx_i;
    assign sum_w = sat_add(acc_q, delta);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            num_q  <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
            avg_q  <= '0;
            rem_q  <= '0;
            err_q  <= 1'b0;
`ifdef RTD_MINMAX_EN
            mn_q   <= '0;
            mx_q   <= '0;
            dmin_q <= '0;
            dmax_q <= '0;
`endif
        end else begin
            num_q  <= num_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            avg_q  <= avg_d;
            rem_q  <= rem_d;
            err_q  <= err_d;
`ifdef RTD_MINMAX_EN
            mn_q   <= mn_d;
            mx_q   <= mx_d;
            dmin_q <= dmin_d;
            dmax_q <= dmax_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        avg_d       = avg_q;
        rem_d       = rem_q;
        err_d       = err_q;
        div_start_o = 1'b0;
`ifdef RTD_MINMAX_EN
        mn_d        = mn_q;
        mx_d        = mx_q;
        dmin_d      = dmin_q;
        dmax_d      = dmax_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (meas_start_i) begin
                    num_d = cfg_num_i;
                    cnt_d = '0;
                    acc_d = '0;
                    if (cfg_num_i == '0) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (sample_vld_i) begin
                    acc_d = sum_w[DW-1:0];
                    if (sum_w[DW]) begin
                        err_d = 1'b1;
                    end
                    cnt_d = cnt_q + 1'b1;
`ifdef RTD_MINMAX_EN
                    if (cnt_q == '0) begin
                        mn_d = delta;
                        mx_d = delta;
                    end else begin
                        if (delta < mn_q) mn_d = delta;
                        if (delta > mx_q) mx_d = delta;
                    end
`endif
                    if (cnt_d == num_q) begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // Operands are already stable here; fire only when the divider can take them.
                if (div_ready_i) begin
                    div_start_o = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (div_end_i) begin
                    avg_d   = div_q_i;
                    rem_d   = div_r_i;
`ifdef RTD_MINMAX_EN
                    dmin_d  = mn_q;
                    dmax_d  = mx_q;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign div_a_o   = acc_q;
    assign div_b_o   = {{(DW-CW){1'b0}}, num_q};
    assign avg_o     = avg_q;
    assign avg_rem_o = rem_q;
    assign avg_vld_o = (state_q == DONE);
    assign busy_o    = (state_q != IDLE);
    assign err_o     = err_q;
`ifdef RTD_MINMAX_EN
    assign dmin_o    = dmin_q;
    assign dmax_o    = dmax_q;
`endif

endmodule

// File: tb/tb_net_rtd_avg.sv
// Bench for net_rtd_avg: transaction-level model of the average plus a behavioural divider.
module tb_net_rtd_avg;
    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          meas_start_i;
    logic [CW-1:0] cfg_num_i;
    logic          sample_vld_i;
    logic [DW-1:0] t_tx_i, t_rx_i;
    logic          div_start_o;
    logic [DW-1:0] div_a_o, div_b_o;
    logic          div_ready_i;
    logic          div_end_i;
    logic [DW-1:0] div_q_i, div_r_i;
    logic [DW-1:0] avg_o, avg_rem_o;
    logic          avg_vld_o, busy_o, err_o;
`ifdef RTD_MINMAX_EN
    logic [DW-1:0] dmin_o, dmax_o;
`endif

    always #5 clk_i = ~clk_i;

    net_rtd_avg #(.DW(DW), .CW(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .meas_start_i(meas_start_i), .cfg_num_i(cfg_num_i),
        .sample_vld_i(sample_vld_i), .t_tx_i(t_tx_i), .t_rx_i(t_rx_i),
        .div_start_o(div_start_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
        .div_ready_i(div_ready_i), .div_end_i(div_end_i), .div_q_i(div_q_i), .div_r_i(div_r_i),
        .avg_o(avg_o), .avg_rem_o(avg_rem_o), .avg_vld_o(avg_vld_o), .busy_o(busy_o),
`ifdef RTD_MINMAX_EN
        .dmin_o(dmin_o), .dmax_o(dmax_o),
`endif
        .err_o(err_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model state
    logic [DW-1:0] txq[$];
    logic [DW-1:0] rxq[$];
    logic [DW-1:0] exp_sum, exp_q, exp_r, exp_min, exp_max;
    logic [CW-1:0] exp_num;
    logic          exp_err;
    logic [DW-1:0] cur_avg, cur_rem, cur_min, cur_max;
    bit            hold_chk = 0;
    bit            bp_hold  = 0;
    bit            div_busy = 0;
    bit            genuine  = 0;
    bit            end_prev = 0;
    logic          dv_end   = 1'b0;
    logic          stray_end;
    int            n_starts = 0;
    int            epoch    = 0;
    int            force_lat = 0;
    logic [DW-1:0] dv_a = '0, dv_b = '0;

    assign div_ready_i = !div_busy && !bp_hold;
    assign div_end_i   = dv_end | stray_end;

    task automatic build_model();
        longint unsigned s;
        longint unsigned lim;
        logic [DW-1:0] d;
        lim = (64'd1 << DW) - 1;
        s = 0;
        exp_err = 1'b0;
        for (int i = 0; i < txq.size(); i++) begin
            d = rxq[i] - txq[i];
            if (i == 0) begin
                exp_min = d;
                exp_max = d;
            end else begin
                if (d < exp_min) exp_min = d;
                if (d > exp_max) exp_max = d;
            end
            s = s + d;
            if (s > lim) begin
                s = lim;
                exp_err = 1'b1;
            end
        end
        exp_sum = s[DW-1:0];
        exp_q   = exp_sum / {{(DW-CW){1'b0}}, exp_num};
        exp_r   = exp_sum % {{(DW-CW){1'b0}}, exp_num};
    endtask

    // Behavioural divider: accepts a request, answers after a few cycles unless reset intervenes.
    initial begin
        int ep;
        int lat;
        div_q_i = '0;
        div_r_i = '0;
        forever begin
            @(negedge clk_i);
            if (rst_ni && div_start_o && div_ready_i) begin
                dv_a = div_a_o;
                dv_b = div_b_o;
                ep   = epoch;
                lat  = (force_lat > 0) ? force_lat : int'($urandom_range(1, 6));
                @(posedge clk_i);
                #1 div_busy = 1;
                for (int i = 0; i < lat && epoch == ep; i++) @(posedge clk_i);
                #1;
                if (epoch == ep) begin
                    dv_end  = 1'b1;
                    genuine = 1;
                    div_q_i = dv_a / dv_b;
                    div_r_i = dv_a % dv_b;
                    @(posedge clk_i);
                    #1 dv_end = 1'b0;
                    genuine = 0;
                    div_q_i = $urandom;
                    div_r_i = $urandom;
                end
                div_busy = 0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            cur_avg  = '0;
            cur_rem  = '0;
            cur_min  = '0;
            cur_max  = '0;
            end_prev = 0;
        end else begin
            chk("avg_vld", avg_vld_o, end_prev);
            if (avg_vld_o) begin
                cur_avg = exp_q;
                cur_rem = exp_r;
                cur_min = exp_min;
                cur_max = exp_max;
                chk("err_at_done", err_o, exp_err);
            end
            chk("avg_o", avg_o, cur_avg);
            chk("avg_rem_o", avg_rem_o, cur_rem);
`ifdef RTD_MINMAX_EN
            chk("dmin_o", dmin_o, cur_min);
            chk("dmax_o", dmax_o, cur_max);
`endif
            if (div_start_o) begin
                n_starts++;
                chk("start_needs_ready", div_ready_i, 1);
            end
            if (hold_chk && busy_o) begin
                chk("div_a_o", div_a_o, exp_sum);
                chk("div_b_o", div_b_o, {{(DW-CW){1'b0}}, exp_num});
            end
            end_prev = div_end_i && genuine;
        end
    end

    task automatic run_meas(input bit bp, input bit inject);
        int n;
        int gap;
        int waited;
        n = txq.size();
        exp_num = n[CW-1:0];
        build_model();
        n_starts = 0;
        @(posedge clk_i);
        #1 meas_start_i = 1'b1;
        cfg_num_i = exp_num;
        @(posedge clk_i);
        #1 meas_start_i = 1'b0;
        cfg_num_i = CW'($urandom);
        @(negedge clk_i);
        chk("busy_after_start", busy_o, 1);
        chk("err_cleared_on_start", err_o, 0);
        for (int i = 0; i < n; i++) begin
            gap = (inject && i == 1) ? 1 : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk_i);
                #1 sample_vld_i = 1'b0;
                t_tx_i = $urandom;
                t_rx_i = $urandom;
                if (inject && i == 1 && g == 0) begin
                    meas_start_i = 1'b1;
                    cfg_num_i    = 8'd9;
                end else begin
                    meas_start_i = 1'b0;
                end
            end
            @(posedge clk_i);
            #1 sample_vld_i = 1'b1;
            meas_start_i = 1'b0;
            t_tx_i = txq[i];
            t_rx_i = rxq[i];
            if (i == n - 1 && bp) bp_hold = 1;
        end
        @(posedge clk_i);
        #1 sample_vld_i = 1'b0;
        hold_chk = 1;
        if (bp) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk_i);
                chk("bp_no_start", div_start_o, 0);
                chk("bp_busy", busy_o, 1);
            end
            @(posedge clk_i);
            #1 bp_hold = 0;
            @(negedge clk_i);
            chk("bp_start_on_ready", div_start_o, 1);
        end else begin
            @(negedge clk_i);
            chk("start_latency", div_start_o, 1);
        end
        waited = 0;
        do begin
            @(negedge clk_i);
            waited++;
        end while (!avg_vld_o && waited < 80);
        chk("avg_vld_seen", avg_vld_o, 1);
        @(posedge clk_i);
        #1 hold_chk = 0;
        chk("one_start", n_starts, 1);
        @(negedge clk_i);
        chk("idle_after_done", busy_o, 0);
    endtask

    initial begin
        int waited;
        rst_ni       = 1'b0;
        meas_start_i = 1'b0;
        cfg_num_i    = '0;
        sample_vld_i = 1'b0;
        t_tx_i       = '0;
        t_rx_i       = '0;
        stray_end    = 1'b0;
        #2;
        chk("rst_busy", busy_o, 0);
        chk("rst_start", div_start_o, 0);
        chk("rst_avg", avg_o, 0);
        chk("rst_rem", avg_rem_o, 0);
        chk("rst_vld", avg_vld_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_div_a", div_a_o, 0);
        chk("rst_div_b", div_b_o, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Basic average
        txq = '{32'd0, 32'd100, 32'd200, 32'd300};
        rxq = '{32'd10, 32'd112, 32'd214, 32'd316};
        run_meas(0, 0);
        chk("basic_div_a", dv_a, 52);
        chk("basic_div_b", dv_b, 4);
        chk("basic_avg", avg_o, 13);
        chk("basic_rem", avg_rem_o, 0);
        chk("basic_err", err_o, 0);

        // Timestamp wrap
        txq = '{32'hFFFF_FFF0};
        rxq = '{32'h0000_0010};
        run_meas(0, 0);
        chk("wrap_div_a", dv_a, 32'h20);
        chk("wrap_avg", avg_o, 32'h20);

        // Zero count
        @(posedge clk_i);
        #1 meas_start_i = 1'b1;
        cfg_num_i = '0;
        @(posedge clk_i);
        #1 meas_start_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk("zero_busy", busy_o, 0);
            chk("zero_start", div_start_o, 0);
            chk("zero_err", err_o, 1);
        end

        // Accumulator overflow
        txq = '{32'd0, 32'd5};
        rxq = '{32'hFFFF_FFFF, 32'd7};
        run_meas(0, 0);
        chk("ovf_div_a", dv_a, 32'hFFFF_FFFF);
        chk("ovf_err", err_o, 1);
        chk("ovf_avg", avg_o, 32'h7FFF_FFFF);

        // Divider backpressure
        txq = '{32'd1, 32'd2, 32'd3};
        rxq = '{32'd11, 32'd22, 32'd33};
        run_meas(1, 0);
        chk("bp_avg", avg_o, 20);

        // Restart attempt during accumulation
        txq = '{32'd0, 32'd0, 32'd0};
        rxq = '{32'd5, 32'd6, 32'd8};
        run_meas(0, 1);
        chk("ignored_start_div_b", dv_b, 3);
        chk("ignored_start_avg", avg_o, 6);
        chk("ignored_start_rem", avg_rem_o, 1);

        // Samples while idle leave the accumulator alone
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            #1 sample_vld_i = 1'b1;
            t_tx_i = $urandom;
            t_rx_i = $urandom;
        end
        @(posedge clk_i);
        #1 sample_vld_i = 1'b0;
        @(negedge clk_i);
        chk("idle_sample_acc", div_a_o, exp_sum);
        chk("idle_sample_busy", busy_o, 0);

        // Stray divider completion while idle
        @(posedge clk_i);
        #1 stray_end = 1'b1;
        @(posedge clk_i);
        #1 stray_end = 1'b0;
        @(negedge clk_i);
        chk("stray_end_avg", avg_o, 6);

        // Randomised measurements
        for (int t = 0; t < 12; t++) begin
            int n;
            txq.delete();
            rxq.delete();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                logic [DW-1:0] tx, d;
                tx = $urandom;
                d  = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 1000));
                txq.push_back(tx);
                rxq.push_back(tx + d);
            end
            run_meas($urandom_range(0, 3) == 0, 0);
        end

        // Reset while waiting on the divider
        txq = '{32'd0, 32'd0};
        rxq = '{32'd100, 32'd200};
        exp_num = 2;
        build_model();
        force_lat = 30;
        @(posedge clk_i);
        #1 meas_start_i = 1'b1;
        cfg_num_i = 8'd2;
        @(posedge clk_i);
        #1 meas_start_i = 1'b0;
        sample_vld_i = 1'b1;
        t_tx_i = txq[0];
        t_rx_i = rxq[0];
        @(posedge clk_i);
        #1 t_tx_i = txq[1];
        t_rx_i = rxq[1];
        @(posedge clk_i);
        #1 sample_vld_i = 1'b0;
        waited = 0;
        while (!div_busy && waited < 20) begin
            @(posedge clk_i);
            waited++;
        end
        chk("reset_test_in_wait", div_busy, 1);
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b0;
        epoch++;
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_start", div_start_o, 0);
        chk("mid_rst_avg", avg_o, 0);
        chk("mid_rst_rem", avg_rem_o, 0);
        chk("mid_rst_vld", avg_vld_o, 0);
        chk("mid_rst_err", err_o, 0);
        chk("mid_rst_div_a", div_a_o, 0);
        chk("mid_rst_div_b", div_b_o, 0);
`ifdef RTD_MINMAX_EN
        chk("mid_rst_dmin", dmin_o, 0);
        chk("mid_rst_dmax", dmax_o, 0);
`endif
        @(negedge clk_i);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        force_lat = 0;
        waited = 0;
        while (div_busy && waited < 40) begin
            @(posedge clk_i);
            waited++;
        end
        @(negedge clk_i);
        chk("post_rst_idle", busy_o, 0);
        txq = '{32'd3};
        rxq = '{32'd10};
        run_meas(0, 0);
        chk("post_rst_avg", avg_o, 7);
        chk("post_rst_rem", avg_rem_o, 0);
`ifdef RTD_MINMAX_EN
        chk("post_rst_dmin", dmin_o, 7);
        chk("post_rst_dmax", dmax_o, 7);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
